// File: rtl/wb_queue.sv
// wb_queue: in-order writeback queue between MEM and the register file.
//
// Holds up to DEPTH results in program order. Each entry keeps its own
// destination, write enable and data. A load entry stays blocked until its
// out-of-band response fills it. The head entry drives the single regfile
// write port. Responses that belong to flushed loads are counted in drop_cnt
// and discarded when they arrive.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               discard every queued entry
//   in_valid/in_ready   MEM result handshake
//   in_rd .. in_is_illegal
//                       fields of the incoming MEM result
//   ld_valid, ld_data   load response, returned in program order
//   rf_we, rf_rd, rf_data
//                       regfile write port, driven by the retiring head
//   pend_mask           bit r set while a queued entry will write register r
//   err_ld              sticky flag for a load response that nothing expects
module wb_queue #(
    parameter int         XLEN    = 32,
    parameter int         DEPTH   = 4,
    parameter int         RADDR_W = 5,
    parameter logic [2:0] TYPE_J  = 3'd3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [RADDR_W-1:0]    in_rd,
    input  logic                  in_is_writeback,
    input  logic                  in_is_load,
    input  logic [2:0]            in_opcode_type,
    input  logic [XLEN-1:0]       in_alu_out,
    input  logic [XLEN-1:0]       in_pc_plus4,
    input  logic [XLEN-1:0]       in_csr_data,
    input  logic                  in_csr_wb,
    input  logic                  in_is_illegal,
    input  logic                  ld_valid,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  rf_we,
    output logic [RADDR_W-1:0]    rf_rd,
    output logic [XLEN-1:0]       rf_data,
    output logic [2**RADDR_W-1:0] pend_mask,
    output logic                  err_ld
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry storage (not reset; occupancy decides which slots are meaningful)
    logic [RADDR_W-1:0] rd_q   [DEPTH];
    logic [XLEN-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0]   wen_q;
    logic [DEPTH-1:0]   wait_q;

    // Control state
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] drop_cnt;
    logic             err_q;

    logic             full;
    logic             accept;
    logic             retire;
    logic             new_wen;
    logic             new_wait;
    logic [XLEN-1:0]  new_data;
    logic [DEPTH-1:0] occ;
    logic             fill_hit;
    logic [PTR_W-1:0] fill_idx;
    logic [CNT_W-1:0] wait_cnt;
    logic             ld_drop;
    logic             ld_fill;
    logic             ld_err;
    logic [CNT_W-1:0] drop_next;

    // Incoming entry decode; a load slot holds the ALU value until its response overwrites it
    assign new_wen  = !in_is_illegal && (in_csr_wb || in_is_writeback) && (in_rd != '0);
    assign new_wait = in_is_load && !in_csr_wb && !in_is_illegal;
    assign new_data = in_csr_wb                   ? in_csr_data :
                      (in_opcode_type == TYPE_J)  ? in_pc_plus4 :
                                                    in_alu_out;

    // Full blocks acceptance even when the head retires in the same cycle
    assign full     = (count == CNT_W'(DEPTH));
    assign in_ready = rst_n && !full;
    assign accept   = in_valid && !full && !flush;
    assign retire   = (count != '0) && !wait_q[head] && !flush;

    assign rf_we   = rst_n && retire && wen_q[head];
    assign rf_rd   = rd_q[head];
    assign rf_data = data_q[head];
    assign err_ld  = err_q;

    // Walk the queue from head: occupancy, outstanding loads, oldest waiting slot
    always_comb begin
        occ      = '0;
        fill_hit = 1'b0;
        fill_idx = '0;
        wait_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                occ[head + PTR_W'(i)] = 1'b1;
                if (wait_q[head + PTR_W'(i)]) begin
                    wait_cnt = wait_cnt + CNT_W'(1);
                    if (!fill_hit) begin
                        fill_hit = 1'b1;
                        fill_idx = head + PTR_W'(i);
                    end
                end
            end
        end
    end

    // Pending mask includes the head even in the cycle it retires
    always_comb begin
        pend_mask = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (rst_n && occ[j] && wen_q[j]) begin
                pend_mask[rd_q[j]] = 1'b1;
            end
        end
    end

    // Responses owed to flushed loads are consumed before any fill
    assign ld_drop = ld_valid && (drop_cnt != '0);
    assign ld_fill = ld_valid && (drop_cnt == '0) && fill_hit;
    assign ld_err  = ld_valid && (drop_cnt == '0) && !fill_hit;

    // A load filled in the flush cycle no longer owes a response
    always_comb begin
        drop_next = drop_cnt;
        if (ld_drop) begin
            drop_next = drop_next - CNT_W'(1);
        end
        if (flush) begin
            drop_next = drop_next + wait_cnt - CNT_W'(ld_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            drop_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            drop_cnt <= drop_next;
            if (ld_err) begin
                err_q <= 1'b1;
            end
            if (flush) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                count <= count + CNT_W'(accept) - CNT_W'(retire);
                head  <= head + PTR_W'(retire);
                tail  <= tail + PTR_W'(accept);
            end
        end
    end

    // Accept writes a free slot and fill writes an occupied one, so they never collide
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q[tail]   <= in_rd;
            data_q[tail] <= new_data;
            wen_q[tail]  <= new_wen;
            wait_q[tail] <= new_wait;
        end
        if (ld_fill) begin
            data_q[fill_idx] <= ld_data;
            wait_q[fill_idx] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Testbench for wb_queue: directed scenarios plus a randomized run checked
// against a queue-based reference model of the writeback rules.
module tb_wb_queue;

    localparam int         DEPTH = 4;
    localparam logic [2:0] TJ    = 3'd3;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [4:0]  in_rd;
    logic        in_is_writeback, in_is_load;
    logic [2:0]  in_opcode_type;
    logic [31:0] in_alu_out, in_pc_plus4, in_csr_data;
    logic        in_csr_wb, in_is_illegal, ld_valid;
    logic [31:0] ld_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [31:0] pend_mask;
    logic        err_ld;

    int checks = 0;
    int failures = 0;

    wb_queue #(.XLEN(32), .DEPTH(DEPTH), .RADDR_W(5), .TYPE_J(TJ)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_is_writeback(in_is_writeback), .in_is_load(in_is_load),
        .in_opcode_type(in_opcode_type), .in_alu_out(in_alu_out), .in_pc_plus4(in_pc_plus4),
        .in_csr_data(in_csr_data), .in_csr_wb(in_csr_wb), .in_is_illegal(in_is_illegal),
        .ld_valid(ld_valid), .ld_data(ld_data), .rf_we(rf_we), .rf_rd(rf_rd),
        .rf_data(rf_data), .pend_mask(pend_mask), .err_ld(err_ld)
    );

    always #5 clk = ~clk;

    // Reference model: queue of entries in program order
    typedef struct {
        logic [4:0]  rd;
        bit          wen;
        logic [31:0] data;
        bit          wt;
    } ent_t;

    ent_t mq[$];
    int   m_drop = 0;
    bit   m_err  = 0;

    function automatic int m_waits();
        int n = 0;
        foreach (mq[i]) if (mq[i].wt) n++;
        return n;
    endfunction

    function automatic bit m_we();
        if (!rst_n || flush || mq.size() == 0) return 1'b0;
        return !mq[0].wt && mq[0].wen;
    endfunction

    function automatic bit m_ready();
        return rst_n && (mq.size() < DEPTH);
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] p = '0;
        if (rst_n) foreach (mq[i]) if (mq[i].wen) p[mq[i].rd] = 1'b1;
        return p;
    endfunction

    function automatic ent_t m_new();
        ent_t e;
        e.rd  = in_rd;
        e.wen = !in_is_illegal && (in_csr_wb || in_is_writeback) && (in_rd != 5'd0);
        e.wt  = in_is_load && !in_csr_wb && !in_is_illegal;
        if (in_csr_wb)              e.data = in_csr_data;
        else if (in_opcode_type == TJ) e.data = in_pc_plus4;
        else                        e.data = in_alu_out;
        return e;
    endfunction

    // Advance the model with the current inputs, then clock the DUT
    task automatic step();
        bit   acc, ret, hit;
        ent_t ne, e;
        acc = in_valid && (mq.size() < DEPTH) && !flush;
        ret = (mq.size() > 0) && !flush && !mq[0].wt;
        ne  = m_new();
        if (!rst_n) begin
            mq.delete();
            m_drop = 0;
            m_err  = 0;
        end else begin
            if (ld_valid) begin
                if (m_drop > 0) m_drop--;
                else begin
                    hit = 0;
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!hit && mq[i].wt) begin
                            e = mq[i]; e.wt = 0; e.data = ld_data; mq[i] = e; hit = 1;
                        end
                    end
                    if (!hit) m_err = 1;
                end
            end
            if (flush) begin
                m_drop += m_waits();
                mq.delete();
            end else begin
                if (ret) void'(mq.pop_front());
                if (acc) mq.push_back(ne);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; ld_valid = 0; ld_data = '0;
        in_rd = '0; in_is_writeback = 0; in_is_load = 0; in_opcode_type = '0;
        in_alu_out = '0; in_pc_plus4 = '0; in_csr_data = '0; in_csr_wb = 0; in_is_illegal = 0;
    endtask

    task automatic push(input logic [4:0] rd, input bit wb, input bit ld, input logic [2:0] typ,
                        input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] csr,
                        input bit csrwb, input bit ill);
        in_valid = 1; in_rd = rd; in_is_writeback = wb; in_is_load = ld; in_opcode_type = typ;
        in_alu_out = alu; in_pc_plus4 = pc4; in_csr_data = csr; in_csr_wb = csrwb; in_is_illegal = ill;
    endtask

    task automatic test_reset();
        idle(); rst_n = 0;
        step(); step();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b want=0", rf_we); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b want=0", in_ready); end
        checks++; if (pend_mask !== 32'h0) begin failures++; $display("FAIL rst_pend got=%h want=0", pend_mask); end
        checks++; if (err_ld !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b want=0", err_ld); end
        rst_n = 1; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_rel_ready got=%0b want=1", in_ready); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_rel_we got=%0b want=0", rf_we); end
    endtask

    task automatic test_alu();
        idle(); push(5'd5, 1, 0, 3'd0, 32'h1234, 32'h0, 32'h0, 0, 0); #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL alu_pre_we got=%0b want=0", rf_we); end
        step(); idle(); #1;
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL alu_we got=%0b want=1", rf_we); end
        checks++; if (rf_rd !== 5'd5) begin failures++; $display("FAIL alu_rd got=%0d want=5", rf_rd); end
        checks++; if (rf_data !== 32'h1234) begin failures++; $display("FAIL alu_data got=%h want=1234", rf_data); end
        checks++; if (pend_mask !== 32'h20) begin failures++; $display("FAIL alu_pend got=%h want=20", pend_mask); end
        step(); #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL alu_post_we got=%0b want=0", rf_we); end
        checks++; if (pend_mask !== 32'h0) begin failures++; $display("FAIL alu_post_pend got=%h want=0", pend_mask); end
    endtask

    task automatic test_load_order();
        idle(); push(5'd3, 1, 1, 3'd0, 32'hDEAD, 32'h0, 32'h0, 0, 0); step();
        push(5'd4, 1, 0, 3'd0, 32'h44, 32'h0, 32'h0, 0, 0); #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL ld_wait_we got=%0b want=0", rf_we); end
        step(); idle(); #1;
        checks++; if (pend_mask !== 32'h18) begin failures++; $display("FAIL ld_pend got=%h want=18", pend_mask); end
        step(); step();
        ld_valid = 1; ld_data = 32'hCAFE; #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL ld_bypass_we got=%0b want=0", rf_we); end
        step(); idle(); #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_data !== 32'hCAFE)
            begin failures++; $display("FAIL ld_first got=%0b/%0d/%h want=1/3/cafe", rf_we, rf_rd, rf_data); end
        step(); #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_data !== 32'h44)
            begin failures++; $display("FAIL ld_second got=%0b/%0d/%h want=1/4/44", rf_we, rf_rd, rf_data); end
        step(); #1;
        checks++; if (rf_we !== 1'b0 || pend_mask !== 32'h0)
            begin failures++; $display("FAIL ld_done got=%0b/%h want=0/0", rf_we, pend_mask); end
    endtask

    task automatic test_mix();
        idle(); push(5'd7, 0, 0, TJ, 32'h111, 32'h100, 32'hC5, 1, 0); step();
        push(5'd8, 1, 0, 3'd0, 32'h888, 32'h0, 32'h0, 0, 1); #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'hC5)
            begin failures++; $display("FAIL mix_csr got=%0b/%0d/%h want=1/7/c5", rf_we, rf_rd, rf_data); end
        step();
        push(5'd0, 1, 0, 3'd0, 32'h777, 32'h0, 32'h0, 0, 0); #1;
        checks++; if (rf_we !== 1'b0 || pend_mask !== 32'h0)
            begin failures++; $display("FAIL mix_illegal got=%0b/%h want=0/0", rf_we, pend_mask); end
        step();
        push(5'd9, 1, 0, TJ, 32'h999, 32'h200, 32'h0, 0, 0); #1;
        checks++; if (rf_we !== 1'b0 || pend_mask !== 32'h0)
            begin failures++; $display("FAIL mix_rd0 got=%0b/%h want=0/0", rf_we, pend_mask); end
        step(); idle(); #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_data !== 32'h200 || pend_mask !== 32'h200)
            begin failures++; $display("FAIL mix_jal got=%0b/%0d/%h/%h want=1/9/200/200", rf_we, rf_rd, rf_data, pend_mask); end
        step(); #1;
        checks++; if (rf_we !== 1'b0 || pend_mask !== 32'h0)
            begin failures++; $display("FAIL mix_empty got=%0b/%h want=0/0", rf_we, pend_mask); end
    endtask

    task automatic test_full();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            push(5'(10 + i), 1, 1, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0); step();
        end
        push(5'd20, 1, 0, 3'd0, 32'h20, 32'h0, 32'h0, 0, 0); #1;
        checks++; if (in_ready !== 1'b0 || pend_mask !== 32'h3C00)
            begin failures++; $display("FAIL full_ready got=%0b/%h want=0/3c00", in_ready, pend_mask); end
        step();
        checks++; if (in_ready !== 1'b0 || pend_mask !== 32'h3C00 || rf_we !== 1'b0)
            begin failures++; $display("FAIL full_hold got=%0b/%h/%0b want=0/3c00/0", in_ready, pend_mask, rf_we); end
        ld_valid = 1; ld_data = 32'hA0; step(); ld_valid = 0; #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_data !== 32'hA0 || in_ready !== 1'b0)
            begin failures++; $display("FAIL full_pop got=%0b/%0d/%h/%0b want=1/10/a0/0", rf_we, rf_rd, rf_data, in_ready); end
        step(); in_valid = 0; #1;
        checks++; if (in_ready !== 1'b1 || pend_mask !== 32'h3800)
            begin failures++; $display("FAIL full_after got=%0b/%h want=1/3800", in_ready, pend_mask); end
        for (int k = 0; k < 8; k++) begin
            ld_valid = (k < 3); ld_data = $urandom; #1;
            checks++; if (rf_we !== m_we() || (m_we() && rf_data !== mq[0].data))
                begin failures++; $display("FAIL full_drain got=%0b/%h want=%0b", rf_we, rf_data, m_we()); end
            step();
        end
    endtask

    task automatic test_flush();
        idle(); push(5'd1, 1, 1, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0); step();
        push(5'd2, 1, 1, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0); step();
        idle(); flush = 1; #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL fl_we got=%0b want=0", rf_we); end
        step(); flush = 0; #1;
        checks++; if (pend_mask !== 32'h0 || in_ready !== 1'b1)
            begin failures++; $display("FAIL fl_empty got=%h/%0b want=0/1", pend_mask, in_ready); end
        push(5'd6, 1, 1, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0); step(); idle();
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1; ld_data = 32'hBAD0 + 32'(k); step(); ld_valid = 0; #1;
            checks++; if (rf_we !== 1'b0 || pend_mask !== 32'h40)
                begin failures++; $display("FAIL fl_drop got=%0b/%h want=0/40", rf_we, pend_mask); end
        end
        ld_valid = 1; ld_data = 32'h600D; step(); ld_valid = 0; #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd6 || rf_data !== 32'h600D || err_ld !== 1'b0)
            begin failures++; $display("FAIL fl_fill got=%0b/%0d/%h/%0b want=1/6/600d/0", rf_we, rf_rd, rf_data, err_ld); end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            idle();
            if ($urandom_range(0, 1) == 1) begin
                push(($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom), 1'($urandom), ($urandom_range(0, 9) < 4),
                     3'($urandom), $urandom, $urandom, $urandom, ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 7) == 0));
                if (in_is_load && !in_csr_wb && !in_is_illegal && (m_waits() + m_drop >= DEPTH)) in_is_load = 0;
            end
            if ((m_waits() + m_drop > 0) && ($urandom_range(0, 9) < 4)) begin
                ld_valid = 1; ld_data = $urandom;
            end
            flush = ($urandom_range(0, 19) == 0);
            #1;
            checks++; if (in_ready !== m_ready()) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b want=%0b", c, in_ready, m_ready()); end
            checks++; if (rf_we !== m_we()) begin failures++; $display("FAIL rnd_we c=%0d got=%0b want=%0b", c, rf_we, m_we()); end
            if (m_we()) begin
                checks++; if (rf_rd !== mq[0].rd || rf_data !== mq[0].data)
                    begin failures++; $display("FAIL rnd_wr c=%0d got=%0d/%h want=%0d/%h", c, rf_rd, rf_data, mq[0].rd, mq[0].data); end
            end
            checks++; if (pend_mask !== m_pend()) begin failures++; $display("FAIL rnd_pend c=%0d got=%h want=%h", c, pend_mask, m_pend()); end
            checks++; if (err_ld !== m_err) begin failures++; $display("FAIL rnd_err c=%0d got=%0b want=%0b", c, err_ld, m_err); end
            step();
        end
    endtask

    task automatic test_err_reset();
        idle(); flush = 1; step(); flush = 0;
        for (int k = 0; k < 8; k++) begin
            ld_valid = (m_drop > 0); ld_data = $urandom; step();
        end
        idle(); #1;
        checks++; if (err_ld !== 1'b0 || pend_mask !== 32'h0)
            begin failures++; $display("FAIL err_pre got=%0b/%h want=0/0", err_ld, pend_mask); end
        ld_valid = 1; ld_data = 32'h5A5A; step(); ld_valid = 0; #1;
        checks++; if (err_ld !== 1'b1) begin failures++; $display("FAIL err_set got=%0b want=1", err_ld); end
        push(5'd9, 1, 0, 3'd0, 32'h99, 32'h0, 32'h0, 0, 0); step(); idle(); #1;
        checks++; if (err_ld !== 1'b1 || rf_we !== 1'b1 || rf_rd !== 5'd9)
            begin failures++; $display("FAIL err_sticky got=%0b/%0b/%0d want=1/1/9", err_ld, rf_we, rf_rd); end
        push(5'd11, 1, 0, 3'd0, 32'hBB, 32'h0, 32'h0, 0, 0); rst_n = 0; #1;
        checks++; if (rf_we !== 1'b0 || in_ready !== 1'b0 || pend_mask !== 32'h0)
            begin failures++; $display("FAIL rst_mid got=%0b/%0b/%h want=0/0/0", rf_we, in_ready, pend_mask); end
        step();
        checks++; if (err_ld !== 1'b0 || rf_we !== 1'b0 || in_ready !== 1'b0)
            begin failures++; $display("FAIL rst_mid_err got=%0b/%0b/%0b want=0/0/0", err_ld, rf_we, in_ready); end
        idle(); rst_n = 1; #1;
        checks++; if (in_ready !== 1'b1 || pend_mask !== 32'h0 || rf_we !== 1'b0)
            begin failures++; $display("FAIL rst_mid_rel got=%0b/%h/%0b want=1/0/0", in_ready, pend_mask, rf_we); end
        step();
        checks++; if (rf_we !== 1'b0 || pend_mask !== 32'h0)
            begin failures++; $display("FAIL rst_mid_drop got=%0b/%h want=0/0", rf_we, pend_mask); end
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_alu();
        test_load_order();
        test_mix();
        test_full();
        test_flush();
        test_random();
        test_err_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
